// File: rtl/rr_packet_mux.sv
// Two-source round-robin packet arbiter feeding a single output register.
// Locks onto a source until its last beat is accepted; also drives the 2:1 mux select s.
module rr_packet_mux #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a_valid,
  input  logic [WIDTH-1:0] a_data,
  input  logic             a_last,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic [WIDTH-1:0] b_data,
  input  logic             b_last,
  output logic             b_ready,
  output logic             s,
  output logic             ot_valid,
  output logic [WIDTH-1:0] ot_data,
  output logic             ot_last,
  input  logic             ot_ready
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOCK_A = 2'd1,
    LOCK_B = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic               prio_q, prio_d;
  logic               ot_valid_q, ot_valid_d;
  logic [WIDTH-1:0]   ot_data_q, ot_data_d;
  logic               ot_last_q, ot_last_d;
  logic               s_q, s_d;

  logic               ld;
  logic               grant_a, grant_b;
  logic               xfer_a, xfer_b;

  // Grant and ready generation; readies are masked while reset is held.
  always_comb begin
    ld      = !ot_valid_q || ot_ready;
    grant_a = 1'b0;
    grant_b = 1'b0;
    case (state_q)
      IDLE: begin
        if (a_valid && (!b_valid || !prio_q)) begin
          grant_a = 1'b1;
        end else if (b_valid) begin
          grant_b = 1'b1;
        end
      end
      LOCK_A:  grant_a = 1'b1;
      LOCK_B:  grant_b = 1'b1;
      default: begin
        grant_a = 1'b0;
        grant_b = 1'b0;
      end
    endcase
    a_ready = grant_a && ld && !rst;
    b_ready = grant_b && ld && !rst;
    xfer_a  = a_valid && a_ready;
    xfer_b  = b_valid && b_ready;
  end

  // Next-state, priority update and output register load/pop.
  always_comb begin
    state_d    = state_q;
    prio_d     = prio_q;
    ot_valid_d = ot_valid_q;
    ot_data_d  = ot_data_q;
    ot_last_d  = ot_last_q;
    s_d        = s_q;

    if (ot_valid_q && ot_ready) begin
      ot_valid_d = 1'b0;
    end

    if (xfer_a) begin
      ot_valid_d = 1'b1;
      ot_data_d  = a_data;
      ot_last_d  = a_last;
      s_d        = 1'b0;
      if (a_last) begin
        state_d = IDLE;
        prio_d  = 1'b1;
      end else begin
        state_d = LOCK_A;
      end
    end else if (xfer_b) begin
      ot_valid_d = 1'b1;
      ot_data_d  = b_data;
      ot_last_d  = b_last;
      s_d        = 1'b1;
      if (b_last) begin
        state_d = IDLE;
        prio_d  = 1'b0;
      end else begin
        state_d = LOCK_B;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      prio_q     <= 1'b0;
      ot_valid_q <= 1'b0;
      ot_data_q  <= '0;
      ot_last_q  <= 1'b0;
      s_q        <= 1'b0;
    end else begin
      state_q    <= state_d;
      prio_q     <= prio_d;
      ot_valid_q <= ot_valid_d;
      ot_data_q  <= ot_data_d;
      ot_last_q  <= ot_last_d;
      s_q        <= s_d;
    end
  end

  assign ot_valid = ot_valid_q;
  assign ot_data  = ot_data_q;
  assign ot_last  = ot_last_q;
  assign s        = s_q;

endmodule

// File: tb/tb_rr_packet_mux.sv
// Directed bench for rr_packet_mux: inputs driven and outputs sampled on the falling edge.
module tb_rr_packet_mux;

  localparam int unsigned WIDTH = 8;

  logic             clk;
  logic             rst;
  logic             a_valid, a_last, a_ready;
  logic [WIDTH-1:0] a_data;
  logic             b_valid, b_last, b_ready;
  logic [WIDTH-1:0] b_data;
  logic             s, ot_valid, ot_last, ot_ready;
  logic [WIDTH-1:0] ot_data;

  int checks;
  int errors;

  rr_packet_mux #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .a_valid  (a_valid),
    .a_data   (a_data),
    .a_last   (a_last),
    .a_ready  (a_ready),
    .b_valid  (b_valid),
    .b_data   (b_data),
    .b_last   (b_last),
    .b_ready  (b_ready),
    .s        (s),
    .ot_valid (ot_valid),
    .ot_data  (ot_data),
    .ot_last  (ot_last),
    .ot_ready (ot_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_out(input string tag, input int unsigned v, input int unsigned d,
                         input int unsigned l, input int unsigned sel);
    chk({tag, ".valid"}, 32'(ot_valid), v);
    chk({tag, ".data"},  32'(ot_data),  d);
    chk({tag, ".last"},  32'(ot_last),  l);
    chk({tag, ".s"},     32'(s),        sel);
  endtask

  task automatic chk_rdy(input string tag, input int unsigned ar, input int unsigned br);
    #1;
    chk({tag, ".a_ready"}, 32'(a_ready), ar);
    chk({tag, ".b_ready"}, 32'(b_ready), br);
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    rst      = 1'b0;
    a_valid  = 1'b1; a_data = 8'h11; a_last = 1'b1;
    b_valid  = 1'b1; b_data = 8'h22; b_last = 1'b1;
    ot_ready = 1'b1;
    #1 rst = 1'b1;

    // Reset held with both sources requesting
    step();
    step();
    chk_rdy("rst", 0, 0);
    chk_out("rst", 0, 'h00, 0, 0);

    // Release: prio 0 favours A, then strict alternation of single-beat packets
    rst = 1'b0;
    chk_rdy("rel", 1, 0);
    step();
    chk_out("rr0", 1, 'h11, 1, 0);
    chk_rdy("rr0", 0, 1);
    step();
    chk_out("rr1", 1, 'h22, 1, 1);
    chk_rdy("rr1", 1, 0);
    step();
    chk_out("rr2", 1, 'h11, 1, 0);
    step();
    chk_out("rr3", 1, 'h22, 1, 1);
    a_valid = 1'b0;
    b_valid = 1'b0;
    step();
    chk_out("drain0", 0, 'h22, 1, 1);

    // Single beat from A (prio is back on A)
    a_valid = 1'b1; a_data = 8'hA5; a_last = 1'b1;
    chk_rdy("single", 1, 0);
    step();
    chk_out("single", 1, 'hA5, 1, 0);
    a_valid = 1'b0;
    step();
    chk_out("drain1", 0, 'hA5, 1, 0);

    // B single beat hands priority back to A
    b_valid = 1'b1; b_data = 8'h77; b_last = 1'b1;
    chk_rdy("b77", 0, 1);
    step();
    chk_out("b77", 1, 'h77, 1, 1);

    // Packet lock: A 01,02,03 while B holds 44
    a_valid = 1'b1; a_data = 8'h01; a_last = 1'b0;
    b_valid = 1'b1; b_data = 8'h44; b_last = 1'b1;
    chk_rdy("lock0", 1, 0);
    step();
    chk_out("lock0", 1, 'h01, 0, 0);
    a_data = 8'h02;
    chk_rdy("lock1", 1, 0);
    step();
    chk_out("lock1", 1, 'h02, 0, 0);
    a_data = 8'h03; a_last = 1'b1;
    chk_rdy("lock2", 1, 0);
    step();
    chk_out("lock2", 1, 'h03, 1, 0);
    a_valid = 1'b0;
    chk_rdy("lock3", 0, 1);
    step();
    chk_out("lock3", 1, 'h44, 1, 1);
    b_valid = 1'b0;
    step();
    chk_out("drain2", 0, 'h44, 1, 1);

    // Backpressure mid-packet: output holds, readies low, no beat lost or duplicated
    a_valid = 1'b1; a_data = 8'h31; a_last = 1'b0;
    step();
    chk_out("bp0", 1, 'h31, 0, 0);
    ot_ready = 1'b0;
    a_data = 8'h32;
    b_valid = 1'b1; b_data = 8'h99; b_last = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk_rdy("bp_hold", 0, 0);
      step();
      chk_out("bp_hold", 1, 'h31, 0, 0);
    end
    ot_ready = 1'b1;
    chk_rdy("bp_rel", 1, 0);
    step();
    chk_out("bp1", 1, 'h32, 0, 0);
    a_data = 8'h33; a_last = 1'b1;
    chk_rdy("bp2", 1, 0);
    step();
    chk_out("bp2", 1, 'h33, 1, 0);
    a_valid = 1'b0;
    step();
    chk_out("bp3", 1, 'h99, 1, 1);
    b_valid = 1'b0;
    step();
    chk_out("drain3", 0, 'h99, 1, 1);

    // Reset after beat 2 of a 3-beat A packet
    a_valid = 1'b1; a_data = 8'h61; a_last = 1'b0;
    step();
    chk_out("mid0", 1, 'h61, 0, 0);
    a_data = 8'h62;
    step();
    chk_out("mid1", 1, 'h62, 0, 0);
    a_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("mid_rst.valid", 32'(ot_valid), 0);
    chk("mid_rst.s", 32'(s), 0);
    chk_rdy("mid_rst", 0, 0);
    step();
    rst = 1'b0;
    b_valid = 1'b1; b_data = 8'h5A; b_last = 1'b1;
    chk_rdy("post_rst", 0, 1);
    step();
    chk_out("post_rst", 1, 'h5A, 1, 1);
    b_valid = 1'b0;
    step();
    chk_out("drain4", 0, 'h5A, 1, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rr_packet_mux.md
# rr_packet_mux

Two-source round-robin packet arbiter with a registered output stage. It sits directly upstream of the 2:1 select mux and also generates that mux's select line `s`. It accepts beats from source A or source B over valid/ready handshakes and locks onto one source until that source's `last` beat is accepted. It then forwards beats one at a time through a single output register.

## Interface
- `WIDTH`, default 8: data width of both input channels and the output.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous reset, active-high.
- `a_valid`  in  1  source A beat valid.
- `a_data`  in  WIDTH  source A beat data.
- `a_last`  in  1  marks the final beat of a source A packet.
- `a_ready`  out  1  source A beat accepted this cycle when high together with `a_valid`.
- `b_valid`, `b_data`, `b_last`, `b_ready`: same as the A signals, for source B.
- `s`  out  1  source of the beat currently held in the output register: 0 = A, 1 = B.
- `ot_valid`  out  1  output register holds a beat.
- `ot_data`  out  WIDTH  output beat data.
- `ot_last`  out  1  output beat is the last beat of its packet.
- `ot_ready`  in  1  downstream accepts the output beat.

## Operation
- Load enable: `ld = !ot_valid || ot_ready`. Whenever `ld` = 0, both `a_ready` and `b_ready` are 0.
- State machine states:
  - `IDLE`: no packet in progress.
  - `LOCK_A`: a packet from A is in progress.
  - `LOCK_B`: a packet from B is in progress.
- Priority register `prio`: 0 favours A, 1 favours B.
- Grant in `IDLE`:
  - Only one source has valid asserted: that source is granted.
  - Both sources valid: the source selected by `prio` is granted. The loser's ready is 0.
  - No source valid: no grant.
- Ready outputs:
  - In `IDLE`: the granted source's ready = `ld`.
  - In `LOCK_x`: `x_ready = ld`; the other source's ready = 0.
- Transfer on `x_valid && x_ready`:
  - The output register loads `x_data` and `x_last`.
  - `ot_valid` is set to 1.
  - `s` is set to the source index.
- State transitions:
  - `IDLE` → `LOCK_x`: on a transfer from x with `last` = 0.
  - `IDLE` stays in `IDLE`: on a transfer with `last` = 1 (single-beat packet).
  - `LOCK_x` → `IDLE`: on a transfer from x with `last` = 1.
  - `LOCK_x` stays in `LOCK_x` for any beat without `last`. It waits indefinitely if `x_valid` drops; there is no timeout and no preemption.
- Packet completion: whenever a beat with `last` = 1 from source x is transferred, `prio` is set to the other source, whether or not the other source is requesting.
- Output register clear: when `ot_valid && ot_ready` and there is no new transfer in the same cycle, `ot_valid` goes to 0. `ot_data`, `ot_last` and `s` keep their values.
- Readies are combinational in state, `prio`, both valids, `ot_valid` and `ot_ready`. Sources must not make `valid` depend on `ready`.
- Data passes through unmodified; there is no width conversion.

## Timing
- Reset values:
  - `ot_valid` = 0, `ot_data` = 0, `ot_last` = 0, `s` = 0.
  - State = `IDLE`, `prio` = 0.
  - `a_ready` = `b_ready` = 0 while `rst` is high.
- Reset takes effect immediately (asynchronously) and releases synchronously at the next edge after deassertion.
- Latency: a beat accepted at edge N appears on `ot_*` after edge N, i.e. one cycle.
- Throughput: one beat per cycle while `ot_ready` is held high, including back-to-back packets from alternating sources with no bubble.
- Backpressure: while `ot_valid && !ot_ready`, `ot_data`, `ot_last` and `s` hold stable and both readies are 0.
- Simultaneous pop and load in the same cycle: the register is replaced by the new beat and `ot_valid` stays 1.
- Reset in the middle of a packet:
  - The packet is abandoned and the output beat is dropped.
  - The block returns to `IDLE` with `prio` = 0.
  - Completing a partially sent packet is the source's responsibility.

## Test plan
- Reset: hold `rst` = 1 with `a_valid` = `b_valid` = 1 → `a_ready` = `b_ready` = 0, `ot_valid` = 0, `s` = 0. After release with `ot_ready` = 1, A (prio 0) is granted first.
- Single beat: `a_data` = 0xA5, `a_last` = 1, `ot_ready` = 1 → `a_ready` = 1 in cycle 0. In cycle 1: `ot_valid` = 1, `ot_data` = 0xA5, `ot_last` = 1, `s` = 0.
- Round-robin: A and B continuously valid with single-beat packets 0x11 and 0x22, `ot_ready` = 1 → `ot_data` sequence is 0x11, 0x22, 0x11, 0x22; `s` alternates 0, 1, 0, 1.
- Packet lock: A sends 0x01, 0x02, 0x03 (last on 0x03) while B holds 0x44 valid → output is 01, 02, 03, 44. `b_ready` stays 0 until 0x03 is transferred.
- Backpressure: `ot_ready` = 0 for 3 cycles while `ot_valid` = 1 → `ot_data` is unchanged and readies are 0. After `ot_ready` returns to 1, every input beat appears exactly once and in order.
- Reset mid-packet: assert `rst` after beat 2 of a 3-beat A packet → `ot_valid` drops to 0 with no clock edge needed. After release, a B-only single beat 0x5A is output with `s` = 1 one cycle after acceptance.
